// File: rtl/conv_sequencer.sv
// -----------------------------------------------------------------------------
// conv_sequencer
//   Sequences a 3x3 sliding-window convolution over an IMG_W x IMG_H image.
//   For every valid output position (r, c) it issues three taps (filter
//   columns k = 0..2). Each tap drives the filter column select and three
//   image row addresses, plus the accumulate strobes for a downstream MAC.
//   The finished pixel is then presented through a valid/ready handshake.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   start      begin a frame (sampled in IDLE only)
//   busy       high from the cycle after start is accepted until done
//   done       one-cycle pulse after the last output handshake
//   filt_cnt   filter column select (combinational from k, 0 outside RUN)
//   img_addr1  image address, window row 0 (registered, tap-aligned)
//   img_addr2  image address, window row 1 (registered, tap-aligned)
//   img_addr3  image address, window row 2 (registered, tap-aligned)
//   mac_en     accumulate the current tap (registered, tap-aligned)
//   acc_clr    with mac_en: load instead of add (first tap of a window)
//   out_valid  accumulated pixel ready
//   out_ready  consumer accepts the pixel
//   out_row    output row of the pixel under out_valid
//   out_col    output column of the pixel under out_valid
// -----------------------------------------------------------------------------
module conv_sequencer #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        filt_cnt,
    output logic [ADDR_W-1:0] img_addr1,
    output logic [ADDR_W-1:0] img_addr2,
    output logic [ADDR_W-1:0] img_addr3,
    output logic              mac_en,
    output logic              acc_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_row,
    output logic [ADDR_W-1:0] out_col
);

    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_R     = ADDR_W'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] LAST_C     = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO        = ADDR_W'(2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_OUT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] c;
    logic [1:0]        k;

    logic              issue;
    logic              accept;
    logic              last_pos;

    // Linear image address of window element (row, col + tap), kept at
    // ADDR_W bits; the parameter rule guarantees the largest one fits.
    function automatic logic [ADDR_W-1:0] tap_addr(
        input logic [ADDR_W-1:0] row,
        input logic [ADDR_W-1:0] col,
        input logic [1:0]        tap
    );
        return row * ROW_STRIDE + col + ADDR_W'(tap);
    endfunction

    assign issue    = (state == S_RUN);
    assign accept   = (state == S_OUT) && out_ready;
    assign last_pos = (r == LAST_R) && (c == LAST_C);

    // Filter column select is combinational so the external filter address
    // register lines up with the registered image addresses one cycle later.
    assign filt_cnt  = issue ? k : 2'd0;
    assign out_valid = (state == S_OUT);
    assign out_row   = r;
    assign out_col   = c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (k == 2'd2) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    state_nxt = last_pos ? S_IDLE : S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage boundary: tap issued in cycle t -> addresses/strobes visible at t+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r         <= '0;
            c         <= '0;
            k         <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mac_en    <= 1'b0;
            acc_clr   <= 1'b0;
            img_addr1 <= '0;
            img_addr2 <= '0;
            img_addr3 <= '0;
        end else begin
            done    <= accept && last_pos;
            mac_en  <= issue;
            acc_clr <= issue && (k == 2'd0);

            if (state == S_IDLE && start) begin
                busy <= 1'b1;
                r    <= '0;
                c    <= '0;
                k    <= 2'd0;
            end else if (accept && last_pos) begin
                busy <= 1'b0;
            end

            if (issue) begin
                k         <= (k == 2'd2) ? 2'd0 : k + 2'd1;
                img_addr1 <= tap_addr(r,        c, k);
                img_addr2 <= tap_addr(r + ONE,  c, k);
                img_addr3 <= tap_addr(r + TWO,  c, k);
            end

            // Row-major advance of the output position on a non-final handshake.
            if (accept && !last_pos) begin
                if (c == LAST_C) begin
                    c <= '0;
                    r <= r + ONE;
                end else begin
                    c <= c + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
module tb_conv_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 4x4 instance
    logic       rst = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic       busy, done, mac_en, acc_clr, out_valid;
    logic [1:0] filt_cnt;
    logic [5:0] img_addr1, img_addr2, img_addr3, out_row, out_col;

    conv_sequencer #(.IMG_W(4), .IMG_H(4), .ADDR_W(6)) u4 (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .filt_cnt(filt_cnt), .img_addr1(img_addr1), .img_addr2(img_addr2),
        .img_addr3(img_addr3), .mac_en(mac_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_col(out_col)
    );

    // 3x3 instance
    logic       rst3 = 1'b1, start3 = 1'b0, out_ready3 = 1'b1;
    logic       busy3, done3, mac_en3, acc_clr3, out_valid3;
    logic [1:0] filt_cnt3;
    logic [3:0] a1_3, a2_3, a3_3, out_row3, out_col3;

    conv_sequencer #(.IMG_W(3), .IMG_H(3), .ADDR_W(4)) u3 (
        .clk(clk), .rst(rst3), .start(start3), .busy(busy3), .done(done3),
        .filt_cnt(filt_cnt3), .img_addr1(a1_3), .img_addr2(a2_3),
        .img_addr3(a3_3), .mac_en(mac_en3), .acc_clr(acc_clr3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_row(out_row3),
        .out_col(out_col3)
    );

    // Filter address register plus MAC with all-ones coefficients and
    // pixel value equal to its address.
    logic [1:0] filt_q = 2'd0;
    int         acc = 0;
    int         ndone = 0;
    int         coef [3] = '{1, 1, 1};

    always @(posedge clk) begin
        filt_q <= filt_cnt;
        if (mac_en)
            acc <= (acc_clr ? 0 : acc) + coef[filt_q] * (int'(img_addr1) + int'(img_addr2) + int'(img_addr3));
        if (done)
            ndone <= ndone + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp))
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset4(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_filt"}, filt_cnt, 0);
        chk({tag, "_a1"}, img_addr1, 0);
        chk({tag, "_a2"}, img_addr2, 0);
        chk({tag, "_a3"}, img_addr3, 0);
        chk({tag, "_mac"}, mac_en, 0);
        chk({tag, "_clr"}, acc_clr, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_row"}, out_row, 0);
        chk({tag, "_col"}, out_col, 0);
    endtask

    // Entered at the first RUN cycle (tap 0 issue) of window (r,c); leaves
    // after the handshake edge.
    task automatic do_window(input int r, input int c, input int hold,
                             input bit poke_run, input bit poke_out);
        chk("run0_filt", filt_cnt, 0);
        chk("run0_mac", mac_en, 0);
        chk("run0_busy", busy, 1);
        chk("run0_valid", out_valid, 0);
        if (poke_run) start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            start = 1'b0;
            chk("tap_filt", filt_cnt, (k < 2) ? k + 1 : 0);
            chk("tap_mac", mac_en, 1);
            chk("tap_clr", acc_clr, (k == 0) ? 1 : 0);
            chk("tap_a1", img_addr1, r * 4 + c + k);
            chk("tap_a2", img_addr2, (r + 1) * 4 + c + k);
            chk("tap_a3", img_addr3, (r + 2) * 4 + c + k);
            chk("tap_fq", filt_q, k);
            chk("tap_valid", out_valid, 0);
        end
        tick();
        chk("out_valid", out_valid, 1);
        chk("out_row", out_row, r);
        chk("out_col", out_col, c);
        chk("out_mac", mac_en, 0);
        chk("out_acc", acc, 36 * r + 9 * c + 45);
        if (hold > 0) begin
            out_ready = 1'b0;
            if (poke_out) start = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                start = 1'b0;
                chk("bp_valid", out_valid, 1);
                chk("bp_row", out_row, r);
                chk("bp_col", out_col, c);
                chk("bp_mac", mac_en, 0);
                chk("bp_busy", busy, 1);
            end
            out_ready = 1'b1;
        end
        tick();
    endtask

    task automatic frame_end(input int done_before);
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_valid", out_valid, 0);
        tick();
        chk("end_done_low", done, 0);
        chk("end_ndone", ndone - done_before, 1);
    endtask

    int nd;

    initial begin
        tick();
        tick();
        chk_reset4("rst");
        chk("rst3_busy", busy3, 0);
        chk("rst3_valid", out_valid3, 0);

        // Frame A: ready tied high
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);
        nd = ndone;
        start = 1'b1;
        tick();
        start = 1'b0;
        do_window(0, 0, 0, 1'b0, 1'b0);
        do_window(0, 1, 0, 1'b0, 1'b0);
        do_window(1, 0, 0, 1'b0, 1'b0);
        do_window(1, 1, 0, 1'b0, 1'b0);
        frame_end(nd);

        // Frame B: backpressure on first pixel, stray starts during RUN/OUT
        nd = ndone;
        start = 1'b1;
        tick();
        start = 1'b0;
        do_window(0, 0, 7, 1'b0, 1'b1);
        do_window(0, 1, 0, 1'b1, 1'b0);
        do_window(1, 0, 2, 1'b1, 1'b1);
        do_window(1, 1, 0, 1'b0, 1'b0);
        frame_end(nd);

        // Frame C: reset at tap 1 of window (1,0), then replay
        start = 1'b1;
        tick();
        start = 1'b0;
        do_window(0, 0, 0, 1'b0, 1'b0);
        do_window(0, 1, 0, 1'b0, 1'b0);
        tick();
        chk("pre_rst_filt", filt_cnt, 1);
        chk("pre_rst_row", out_row, 1);
        nd = ndone;
        rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_reset4("midrst");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("postrst_valid", out_valid, 0);
            chk("postrst_busy", busy, 0);
        end
        chk("postrst_ndone", ndone - nd, 0);
        nd = ndone;
        start = 1'b1;
        tick();
        start = 1'b0;
        do_window(0, 0, 0, 1'b0, 1'b0);
        do_window(0, 1, 0, 1'b0, 1'b0);
        do_window(1, 0, 0, 1'b0, 1'b0);
        do_window(1, 1, 0, 1'b0, 1'b0);
        frame_end(nd);

        // Minimal 3x3 image: a single output
        rst3 = 1'b0;
        tick();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("m_busy", busy3, 1);
        chk("m_mac0", mac_en3, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("m_mac", mac_en3, 1);
            chk("m_clr", acc_clr3, (k == 0) ? 1 : 0);
            chk("m_a1", a1_3, k);
            chk("m_a2", a2_3, 3 + k);
            chk("m_a3", a3_3, 6 + k);
        end
        tick();
        chk("m_valid", out_valid3, 1);
        chk("m_row", out_row3, 0);
        chk("m_col", out_col3, 0);
        tick();
        chk("m_done", done3, 1);
        chk("m_busy_end", busy3, 0);
        chk("m_valid_end", out_valid3, 0);
        tick();
        chk("m_done_low", done3, 0);
        chk("m_mac_end", mac_en3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
